// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm_timer register map and its configuration sequencer.
package pwm_pkg;

  localparam int unsigned PWM_ADR_CTRL   = 0;
  localparam int unsigned PWM_ADR_DIV    = 1;
  localparam int unsigned PWM_ADR_PERIOD = 2;
  localparam int unsigned PWM_ADR_DC     = 3;

  // ctrl register bit positions, shared with pwm_timer
  localparam int unsigned PWM_CTRL_EN_BIT     = 0;
  localparam int unsigned PWM_CTRL_OUT_EN_BIT = 1;
  localparam int unsigned PWM_CTRL_POL_BIT    = 2;
  localparam int unsigned PWM_CTRL_IRQ_EN_BIT = 4;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_CHECK,
    SEQ_WRITE,
    SEQ_GAP,
    SEQ_FIN
  } seq_state_t;

  // Write-list order: ctrl goes last so the counter starts only once fully configured.
  function automatic int unsigned seq_adr(input logic [1:0] idx);
    case (idx)
      2'd0:    seq_adr = PWM_ADR_PERIOD;
      2'd1:    seq_adr = PWM_ADR_DC;
      2'd2:    seq_adr = PWM_ADR_DIV;
      default: seq_adr = PWM_ADR_CTRL;
    endcase
  endfunction

endpackage

// File: rtl/wb_write_master.sv
// Single Wishbone write: holds adr/data from req until ack or wait timeout.
module wb_write_master #(
  parameter int DW          = 16,
  parameter int AW          = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [AW-1:0] req_adr,
  input  logic [DW-1:0] req_data,
  input  logic          wb_ack,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [DW-1:0] wb_data,
  output logic          done,
  output logic          timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT);

  logic          active;
  logic [CW-1:0] wait_cnt;

  // ack wins over a timeout landing on the same edge
  assign done    = active & wb_ack;
  assign timeout = active & ~wb_ack & (wait_cnt == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      wait_cnt <= '0;
      wb_adr   <= '0;
      wb_data  <= '0;
    end else if (req) begin
      active   <= 1'b1;
      wait_cnt <= '0;
      wb_adr   <= req_adr;
      wb_data  <= req_data;
    end else if (active) begin
      if (done || timeout) active <= 1'b0;
      else                 wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign wb_cyc = active;
  assign wb_stb = active;
  assign wb_we  = active;

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Programs the pwm_timer register file over Wishbone from one start pulse (full config or dc-only).
module pwm_cfg_sequencer
  import pwm_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_dc_only,
  input  logic [DW-1:0] i_period,
  input  logic [DW-1:0] i_dc,
  input  logic [DW-1:0] i_divisor,
  input  logic [DW-1:0] i_ctrl,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_adr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack
);

  seq_state_t    state, state_nxt;
  logic [DW-1:0] period_q, dc_q, div_q, ctrl_q;
  logic          dc_only_q;
  logic [1:0]    idx, req_idx;
  logic          req, wr_done, wr_timeout, last;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_data;

  // dc-only is a one-entry list starting at the dc slot
  assign last = dc_only_q || (idx == 2'd3);

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    req_idx   = idx;
    case (state)
      SEQ_IDLE:  if (i_start) state_nxt = SEQ_CHECK;
      SEQ_CHECK: begin
        if (!dc_only_q && (dc_q > period_q)) begin
          state_nxt = SEQ_FIN;
        end else begin
          state_nxt = SEQ_WRITE;
          req       = 1'b1;
          req_idx   = dc_only_q ? 2'd1 : 2'd0;
        end
      end
      SEQ_WRITE: begin
        if (wr_done)         state_nxt = last ? SEQ_FIN : SEQ_GAP;
        else if (wr_timeout) state_nxt = SEQ_FIN;
      end
      SEQ_GAP: begin
        state_nxt = SEQ_WRITE;
        req       = 1'b1;
        req_idx   = idx + 2'd1;
      end
      SEQ_FIN:   state_nxt = SEQ_IDLE;
      default:   state_nxt = SEQ_IDLE;
    endcase
  end

  always_comb begin
    req_adr = AW'(seq_adr(req_idx));
    case (req_idx)
      2'd0:    req_data = period_q;
      2'd1:    req_data = dc_q;
      2'd2:    req_data = div_q;
      default: req_data = ctrl_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= SEQ_IDLE;
      period_q  <= '0;
      dc_q      <= '0;
      div_q     <= '0;
      ctrl_q    <= '0;
      dc_only_q <= 1'b0;
      idx       <= '0;
      o_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req) idx <= req_idx;
      if (state == SEQ_IDLE && i_start) begin
        period_q  <= i_period;
        dc_q      <= i_dc;
        div_q     <= i_divisor;
        ctrl_q    <= i_ctrl;
        dc_only_q <= i_dc_only;
        o_err     <= 1'b0;
      end
      if (state == SEQ_CHECK && !dc_only_q && (dc_q > period_q)) o_err <= 1'b1;
      if (state == SEQ_WRITE && wr_timeout)                      o_err <= 1'b1;
    end
  end

  assign o_busy = (state == SEQ_CHECK) || (state == SEQ_WRITE) || (state == SEQ_GAP);
  assign o_done = (state == SEQ_FIN);

  wb_write_master #(
    .DW          (DW),
    .AW          (AW),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_wr (
    .clk      (i_clk),
    .rst      (i_rst),
    .req      (req),
    .req_adr  (req_adr),
    .req_data (req_data),
    .wb_ack   (i_wb_ack),
    .wb_cyc   (o_wb_cyc),
    .wb_stb   (o_wb_stb),
    .wb_we    (o_wb_we),
    .wb_adr   (o_wb_adr),
    .wb_data  (o_wb_data),
    .done     (wr_done),
    .timeout  (wr_timeout)
  );

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
Wishbone master that programs the pwm_timer slave register file (ctrl 0x0, divisor 0x1, period 0x2, dc 0x3) from a single start pulse. Supports two commands: a full configuration (period, dc, divisor, then ctrl last, so the counter is enabled only after all other registers are written) and a dc-only update. Sits between the system control logic and the pwm_timer Wishbone port; it does not perform bus reads.

Parameters:
DW, 16, Wishbone data width; also the width of all configuration values.
AW, 4, Wishbone address width.
ACK_TIMEOUT, 16, maximum number of cycles a write waits for ack before aborting; minimum 2.

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_start  in  1  command strobe; sampled only in IDLE
i_dc_only  in  1  sampled with i_start; 1 = write dc only
i_period  in  DW  period value, latched at accepted start
i_dc  in  DW  duty value, latched at accepted start
i_divisor  in  DW  divisor value, latched at accepted start
i_ctrl  in  DW  ctrl value, latched at accepted start
o_busy  out  1  high from the cycle after an accepted start until the cycle of o_done
o_done  out  1  one-cycle pulse when a command ends (success, abort or reject)
o_err  out  1  sticky error flag; cleared on the next accepted start
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
o_wb_we  out  1  write enable; always equal to o_wb_stb
o_wb_adr  out  AW  register address
o_wb_data  out  DW  write data
i_wb_ack  in  1  slave acknowledge

Behaviour:
- Clock and reset: single clock i_clk. i_rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; latched values 0.
- States: IDLE, CHECK, WRITE, GAP, FIN.
- IDLE:
  - If i_start=1, latch all inputs, clear o_err and go to CHECK.
  - i_start in any other state is ignored, with no queuing.
- CHECK (one cycle, o_busy=1):
  - Full command with latched dc > period: set o_err and go to FIN. No bus activity.
  - dc == period is legal.
  - dc-only commands skip this check.
  - Otherwise load the write list and go to WRITE.
- Write lists:
  - Full: adr 2 (period), adr 3 (dc), adr 1 (divisor), adr 0 (ctrl).
  - dc-only: adr 3 (dc).
- WRITE:
  - o_wb_cyc, o_wb_stb and o_wb_we are high, with adr/data stable for the whole transaction.
  - Wait counter starts at 0 on entry and increments each cycle that i_wb_ack=0.
  - i_wb_ack=1 at a clock edge ends the transaction. cyc/stb/we are low in the following cycle.
  - If more entries remain, go to GAP. Otherwise go to FIN.
  - If the counter reaches ACK_TIMEOUT-1 with no ack, abort: deassert the bus next cycle, set o_err, go to FIN. Remaining writes are not issued.
  - An ack arriving on the same edge as the timeout counts as success (ack has priority).
- GAP: exactly one cycle with cyc/stb low, then WRITE with the next entry. Back-to-back transactions are therefore separated by exactly one idle cycle.
- FIN: o_done=1 for one cycle, o_busy=0, then IDLE. A new start is accepted on the cycle after FIN.
- Stray acks: i_wb_ack outside WRITE is ignored.
- o_wb_adr/o_wb_data outside WRITE: hold their last value (no requirement on value while stb is low).
- Reset mid-command: bus signals drop asynchronously and the command is lost with no o_done.
- Latency, full command with zero-wait slave (ack in first WRITE cycle): start edge → CHECK → W(2) → G → W(3) → G → W(1) → G → W(0) → FIN. o_done occurs 9 cycles after the start edge.
- Latency, dc-only command with zero-wait slave: o_done occurs 3 cycles after the start edge.

Decomposition:
- Shared package pwm_pkg holds:
  - Register address constants: PWM_ADR_CTRL=0, PWM_ADR_DIV=1, PWM_ADR_PERIOD=2, PWM_ADR_DC=3.
  - Ctrl bit-position constants, reused by pwm_timer.
  - The sequencer state enum.
- One natural sub-module: wb_write_master. It performs a single write with ack/timeout and returns done/timeout. pwm_cfg_sequencer holds the command FSM and write list.

Test Plan:
- Full command (period=100, dc=40, div=4, ctrl=0x0016), zero-wait slave → four writes in order adr 2,3,1,0 with data 100,40,4,0x0016; one idle cycle between writes; o_done 9 cycles after start; o_err=0.
- dc-only command, dc=50, slave acks after 3 wait cycles → single write adr 3 data 50 with stb held 4 cycles; o_done pulse; pwm_timer reads back dc=50.
- Full command with dc=120 > period=100 → no cyc assertion; o_err=1 and o_done 2 cycles after start. A following valid start clears o_err.
- Slave never acks on the dc write (ACK_TIMEOUT=16) → period write completes; dc write stb high for exactly 16 cycles, then drops; divisor/ctrl never issued; o_err=1, o_done=1.
- i_start pulsed while busy, plus a stray ack during GAP → both ignored; write sequence and data unchanged.
- i_rst asserted mid-WRITE (between clock edges) → cyc/stb/we low immediately, no o_done. After release, a new start runs a normal full sequence.
